lab_self_test: RTL and testbench

LAB_SELF_TEST -- requirements
Module: lab_self_test

---
 rtl/lab_self_test.sv | 99 +++++++++
 tb/tb_lab_self_test.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lab_self_test.sv
// Board self-test sequencer: sweeps all 256 switch patterns, waits for the
// board to settle, then compares the LED response against the reference logic.
module lab_self_test #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] led_in,
    output logic [7:0] sw_drive,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [7:0] fail_vector
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [7:0] RELOAD  = 8'(SETTLE_CYCLES - 1);
    localparam logic [8:0] ERR_MAX = 9'd256;

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic [2:0] sum;
    logic [5:0] exp_led;
    logic       mismatch;

    // Reference behaviour of the board-level design for the current pattern
    always_comb begin
        sum      = {1'b0, sw_drive[5:4]} + {1'b0, sw_drive[7:6]};
        exp_led  = {sum,
                    sw_drive[2] & sw_drive[3],
                    sw_drive[2] ^ sw_drive[3],
                    sw_drive[0] ^ sw_drive[1]};
        mismatch = (led_in != exp_led);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = SETTLE;
            SETTLE:     if (cnt == 8'd0) state_nx = CHECK;
            CHECK:      state_nx = (sw_drive == 8'hFF) ? DONE : SETTLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 8'd0;
            sw_drive    <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= 9'd0;
            fail_vector <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count   <= 9'd0;
                        fail_vector <= 8'h00;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        sw_drive    <= 8'h00;
                        busy        <= 1'b1;
                        cnt         <= RELOAD;
                    end
                end
                SETTLE: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) err_count <= err_count + 9'd1;
                        // err_count still zero here means this is the first miss
                        if (err_count == 9'd0) fail_vector <= sw_drive;
                    end
                    if (sw_drive != 8'hFF) begin
                        sw_drive <= sw_drive + 8'd1;
                        cnt      <= RELOAD;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !mismatch && (err_count == 9'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lab_self_test.sv
// Directed/randomized bench for lab_self_test with a board model that can
// inject faults and a reference tally of expected mismatches.
module tb_lab_self_test;

    logic       clk = 1'b0;
    logic       reset, start, start1;
    logic [5:0] led_in, led_in1;
    logic [7:0] sw_drive, sw_drive1, fail_vector, fail_vector1;
    logic       busy, done, pass, busy1, done1, pass1;
    logic [8:0] err_count, err_count1;

    int         checks = 0;
    int         errors = 0;
    int         mode   = 0;
    logic [5:0] mask [256];

    always #5 clk = ~clk;

    lab_self_test dut (
        .clk(clk), .reset(reset), .start(start), .led_in(led_in),
        .sw_drive(sw_drive), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vector(fail_vector)
    );

    lab_self_test #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .led_in(led_in1),
        .sw_drive(sw_drive1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_vector(fail_vector1)
    );

    // Correct board behaviour, from plain arithmetic on the switch value
    function automatic logic [5:0] golden(input logic [7:0] v);
        int s, b0, b1, b2;
        s  = ((int'(v) >> 4) & 3) + ((int'(v) >> 6) & 3);
        b0 = (v[0] != v[1]) ? 1 : 0;
        b1 = (v[2] != v[3]) ? 1 : 0;
        b2 = (v[2] && v[3]) ? 1 : 0;
        return 6'(s * 8 + b2 * 4 + b1 * 2 + b0);
    endfunction

    function automatic logic [5:0] board(input logic [7:0] v, input int m);
        logic [5:0] g;
        g = golden(v);
        case (m)
            1:       return g & 6'h3E;
            2:       return g & 6'h1F;
            3:       return ~g;
            4:       return g ^ mask[v];
            default: return g;
        endcase
    endfunction

    assign led_in  = board(sw_drive, mode);
    assign led_in1 = golden(sw_drive1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic ref_tally(input int m, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int v = 0; v < 256; v++) begin
            if (board(8'(v), m) != golden(8'(v))) begin
                if (cnt == 0) first = v;
                cnt++;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/sw"},   32'(sw_drive),    0);
        check({tag, "/busy"}, 32'(busy),        0);
        check({tag, "/done"}, 32'(done),        0);
        check({tag, "/pass"}, 32'(pass),        0);
        check({tag, "/err"},  32'(err_count),   0);
        check({tag, "/fv"},   32'(fail_vector), 0);
    endtask

    // One full run; optional start pulse at cycle midpulse must be ignored
    task automatic run(input int m, input string tag, input int midpulse);
        int cyc, ecnt, efirst;
        mode = m;
        ref_tally(m, ecnt, efirst);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "/busy_on"}, 32'(busy), 1);
        check({tag, "/done_off"}, 32'(done), 0);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
            start = (midpulse != 0 && cyc == midpulse);
        end
        start = 1'b0;
        check({tag, "/cycles"}, 32'(cyc), 1280);
        check({tag, "/err"},    32'(err_count), 32'(ecnt));
        check({tag, "/fv"},     32'(fail_vector), 32'(efirst));
        check({tag, "/pass"},   32'(pass), (ecnt == 0) ? 1 : 0);
        check({tag, "/busy"},   32'(busy), 0);
        check({tag, "/sw"},     32'(sw_drive), 32'hFF);
    endtask

    initial begin
        int cyc, first_done, second_done, seen_low;
        reset = 1'b1; start = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 256; i++) mask[i] = 6'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        run(0, "golden", 0);
        run(1, "stuck0", 0);
        check("stuck0/err_const", 32'(err_count), 128);
        check("stuck0/fv_const",  32'(fail_vector), 32'h01);
        run(2, "stuck5", 0);
        check("stuck5/err_const", 32'(err_count), 96);
        check("stuck5/fv_const",  32'(fail_vector), 32'h70);
        run(3, "allbad", 0);
        check("allbad/saturate", 32'(err_count), 256);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 256; i++)
                mask[i] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
            run(4, "rand_midstart", 300 + 200 * k);
        end
        run(0, "golden_after_fail", 0);

        // Abort mid-run: outputs must clear without a clock edge
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (600) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk) reset = 1'b0;
        run(0, "after_reset", 0);

        // start held high: one run, then an immediate restart from DONE
        mode = 0;
        @(negedge clk) start = 1'b1;
        cyc = 0; first_done = 0; second_done = 0; seen_low = 0;
        while (cyc < 3000 && second_done == 0) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc >= 2000) start = 1'b0;
            if (first_done == 0) begin
                if (done) first_done = cyc;
            end else if (seen_low == 0) begin
                if (!done) begin
                    seen_low = cyc;
                    check("hold/restart_busy", 32'(busy), 1);
                end
            end else if (done) second_done = cyc;
        end
        start = 1'b0;
        check("hold/first_done",  32'(first_done), 1281);
        check("hold/restart_cyc", 32'(seen_low), 1282);
        check("hold/second_done", 32'(second_done), 2562);
        check("hold/pass",        32'(pass), 1);

        // Minimum settle time
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check("settle1/cycles", 32'(cyc), 512);
        check("settle1/pass",   32'(pass1), 1);
        check("settle1/err",    32'(err_count1), 0);
        check("settle1/fv",     32'(fail_vector1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
